// File: rtl/gesture_frame_ctrl_pkg.sv
// Shared encodings for the gesture frame sequencer: FSM state codes and
// processing-mode codes understood by the downstream rgb2ycbcr / gesture chain.
package gesture_frame_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SKIP = 3'd1;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic [1:0] MODE_RGB     = 2'd0;
  localparam logic [1:0] MODE_YCBCR   = 2'd1;
  localparam logic [1:0] MODE_MASK    = 2'd2;
  localparam logic [1:0] MODE_OVERLAY = 2'd3;

endpackage

// File: rtl/frame_geom_meas.sv
// Frame geometry tracker: vsync/valid edge detect, saturating pixel/line
// counters and a per-frame geometry error flag.
module frame_geom_meas
  import gesture_frame_ctrl_pkg::*;
#(
  parameter int EXP_PIX  = 640,
  parameter int EXP_LINE = 480,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vsync,
  input  logic             in_clken,
  input  logic             in_valid,
  output logic             vs_rise,
  output logic             vs_fall,
  output logic             err,
  output logic [CNT_W-1:0] pix_last,
  output logic [CNT_W-1:0] line_cnt
);

  logic             vs_d;
  logic             val_d;
  logic             line_end;
  logic             err_q;
  logic [CNT_W-1:0] pix_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign vs_rise  = in_vsync & ~vs_d;
  assign vs_fall  = ~in_vsync & vs_d;
  assign line_end = val_d & ~in_valid & in_vsync;

  // The line-count check is folded in combinationally so the FSM sees the
  // complete verdict on the same edge that samples vs_fall.
  assign err = err_q | (line_cnt != CNT_W'(EXP_LINE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      val_d    <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      pix_last <= '0;
      err_q    <= 1'b0;
    end else begin
      vs_d  <= in_vsync;
      val_d <= in_valid;

      if (vs_rise || line_end)
        pix_cnt <= '0;
      else if (in_clken && in_valid)
        pix_cnt <= sat_inc(pix_cnt);

      if (vs_rise)
        line_cnt <= '0;
      else if (line_end)
        line_cnt <= sat_inc(line_cnt);

      if (vs_rise)
        pix_last <= '0;
      else if (line_end)
        pix_last <= pix_cnt;

      if (vs_rise)
        err_q <= 1'b0;
      else if ((line_end && (pix_cnt != CNT_W'(EXP_PIX))) ||
               (vs_fall && (line_cnt != CNT_W'(EXP_LINE))))
        err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/gesture_frame_ctrl.sv
// Frame-level sequencer between camera capture and the gesture pipeline:
// skips settling frames, gates processing on whole frames, reports geometry.
module gesture_frame_ctrl
  import gesture_frame_ctrl_pkg::*;
#(
  parameter int SKIP_FRAMES = 10,
  parameter int EXP_PIX     = 640,
  parameter int EXP_LINE    = 480,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_start,
  input  logic             ctrl_stop,
  input  logic [1:0]       mode_req,
  input  logic             in_vsync,
  input  logic             in_clken,
  input  logic             in_valid,
  output logic             proc_en,
  output logic [1:0]       mode_cur,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] meas_pix,
  output logic [CNT_W-1:0] meas_line,
  output logic             busy
);

  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST =
    (SKIP_FRAMES > 0) ? SKIP_W'(SKIP_FRAMES - 1) : '0;

  logic              vs_rise;
  logic              vs_fall;
  logic              geom_err;
  logic [CNT_W-1:0]  pix_last;
  logic [CNT_W-1:0]  line_cnt;

  logic [2:0]        state;
  logic [2:0]        state_n;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_cnt_n;
  logic              stop_pend;
  logic              stop_pend_n;
  logic              accept;
  logic              finish;

  frame_geom_meas #(
    .EXP_PIX  (EXP_PIX),
    .EXP_LINE (EXP_LINE),
    .CNT_W    (CNT_W)
  ) u_geom (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vsync (in_vsync),
    .in_clken (in_clken),
    .in_valid (in_valid),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .err      (geom_err),
    .pix_last (pix_last),
    .line_cnt (line_cnt)
  );

  always_comb begin
    state_n     = state;
    skip_cnt_n  = skip_cnt;
    stop_pend_n = stop_pend;
    accept      = 1'b0;
    finish      = 1'b0;
    case (state)
      ST_IDLE: begin
        stop_pend_n = 1'b0;
        if (ctrl_start && !ctrl_stop) begin
          skip_cnt_n = '0;
          state_n    = (SKIP_FRAMES == 0) ? ST_ARM : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (ctrl_stop)
          state_n = ST_IDLE;
        else if (vs_fall) begin
          if (skip_cnt == SKIP_LAST)
            state_n = ST_ARM;
          else
            skip_cnt_n = skip_cnt + SKIP_W'(1);
        end
      end
      // Entering on vs_rise only means a frame already under way is never taken.
      ST_ARM, ST_GAP: begin
        if (ctrl_stop)
          state_n = ST_IDLE;
        else if (vs_rise) begin
          accept  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ctrl_stop)
          stop_pend_n = 1'b1;
        if (vs_fall) begin
          finish      = 1'b1;
          stop_pend_n = 1'b0;
          state_n     = (stop_pend || ctrl_stop) ? ST_IDLE : ST_GAP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      skip_cnt    <= '0;
      stop_pend   <= 1'b0;
      proc_en     <= 1'b0;
      mode_cur    <= 2'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
      meas_pix    <= '0;
      meas_line   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      skip_cnt    <= skip_cnt_n;
      stop_pend   <= stop_pend_n;
      proc_en     <= (state_n == ST_RUN);
      busy        <= (state_n != ST_IDLE);
      frame_start <= accept;
      frame_done  <= finish;
      frame_err   <= finish & geom_err;
      if (accept)
        mode_cur <= mode_req;
      if (finish) begin
        frame_cnt <= frame_cnt + 16'd1;
        meas_pix  <= pix_last;
        meas_line <= line_cnt;
      end
    end
  end

endmodule

// File: tb/tb_gesture_frame_ctrl.sv
// Directed bench for gesture_frame_ctrl: a frame table drives a small camera
// model into a SKIP_FRAMES=2 instance and a SKIP_FRAMES=0 instance.
module tb_gesture_frame_ctrl;
  import gesture_frame_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ctrl_start, ctrl_stop, start0, in_vsync, in_clken, in_valid;
  logic        stop0 = 1'b0;
  logic [1:0]  mode_req;

  logic        proc_en, frame_start, frame_done, frame_err, busy;
  logic [1:0]  mode_cur;
  logic [15:0] frame_cnt;
  logic [11:0] meas_pix, meas_line;

  logic        proc_en0, frame_start0, frame_done0, frame_err0, busy0;
  logic [1:0]  mode_cur0;
  logic [15:0] frame_cnt0;
  logic [11:0] meas_pix0, meas_line0;

  int   checks = 0;
  int   failures = 0;
  int   act_cnt = 0;
  bit   watch = 1'b0;
  logic [1:0] prev_mode;

  gesture_frame_ctrl #(.SKIP_FRAMES(2), .EXP_PIX(30), .EXP_LINE(11), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .mode_req(mode_req), .in_vsync(in_vsync), .in_clken(in_clken), .in_valid(in_valid),
    .proc_en(proc_en), .mode_cur(mode_cur), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .meas_pix(meas_pix), .meas_line(meas_line), .busy(busy)
  );

  gesture_frame_ctrl #(.SKIP_FRAMES(0), .EXP_PIX(30), .EXP_LINE(11), .CNT_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl_start(start0), .ctrl_stop(stop0),
    .mode_req(mode_req), .in_vsync(in_vsync), .in_clken(in_clken), .in_valid(in_valid),
    .proc_en(proc_en0), .mode_cur(mode_cur0), .frame_start(frame_start0),
    .frame_done(frame_done0), .frame_err(frame_err0), .frame_cnt(frame_cnt0),
    .meas_pix(meas_pix0), .meas_line(meas_line0), .busy(busy0)
  );

  always @(negedge clk)
    if (watch && (frame_start || frame_done || proc_en || busy ||
                  frame_start0 || frame_done0 || proc_en0 || busy0))
      act_cnt <= act_cnt + 1;

  typedef struct {
    bit          start_main;
    int          poke;       // 0 none, 1 stop mid-frame, 2 stop with vsync rise, 3 start dut0 mid-frame
    int          nlines;
    int          npix;
    logic [1:0]  mode_pre;
    logic [1:0]  mode_mid;
    bit          acc;
    bit          acc0;
    bit          err;
    logic [15:0] cnt;
    logic [11:0] mpix;
    logic [11:0] mline;
    logic [1:0]  mode;
    bit          busy;
  } vec_t;

  vec_t vt[16];
  vec_t vrst;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic blank(input int n);
    repeat (n * 66) tick;
  endtask

  task automatic line(input int npix);
    for (int c = 0; c < 2 * npix; c++) begin
      in_valid = 1'b1;
      in_clken = (c % 2 == 0);
      tick;
    end
    in_valid = 1'b0;
    in_clken = 1'b0;
    repeat (6) tick;
  endtask

  task automatic run_row(input int i, input vec_t v);
    if (v.start_main) begin
      ctrl_start = 1'b1;
      tick;
      ctrl_start = 1'b0;
      chk($sformatf("r%0d start_busy", i), 64'(busy), 64'(1));
    end
    mode_req = v.mode_pre;
    repeat (4) tick;
    chk($sformatf("r%0d mode_hold", i), 64'(mode_cur), 64'(prev_mode));
    in_vsync = 1'b1;
    if (v.poke == 2) ctrl_stop = 1'b1;
    tick;
    ctrl_stop = 1'b0;
    chk($sformatf("r%0d frame_start", i), 64'(frame_start), 64'(v.acc));
    chk($sformatf("r%0d proc_en_rise", i), 64'(proc_en), 64'(v.acc));
    chk($sformatf("r%0d mode_cur", i), 64'(mode_cur), 64'(v.mode));
    chk($sformatf("r%0d frame_start0", i), 64'(frame_start0), 64'(v.acc0));
    if (v.poke == 2) chk($sformatf("r%0d stop_rise_busy", i), 64'(busy), 64'(0));
    mode_req = v.mode_mid;
    blank(2);
    for (int l = 0; l < v.nlines; l++) begin
      if (l == 3) begin
        if (v.poke == 1) ctrl_stop = 1'b1;
        if (v.poke == 3) start0 = 1'b1;
        tick;
        ctrl_stop = 1'b0;
        start0 = 1'b0;
      end
      if (l == 5) begin
        chk($sformatf("r%0d proc_en_mid", i), 64'(proc_en), 64'(v.acc));
        chk($sformatf("r%0d proc_en0_mid", i), 64'(proc_en0), 64'(v.acc0));
      end
      line(v.npix);
    end
    blank(3);
    in_vsync = 1'b0;
    tick;
    chk($sformatf("r%0d frame_done", i), 64'(frame_done), 64'(v.acc));
    chk($sformatf("r%0d frame_err", i), 64'(frame_err), 64'(v.acc & v.err));
    chk($sformatf("r%0d proc_en_fall", i), 64'(proc_en), 64'(0));
    chk($sformatf("r%0d frame_cnt", i), 64'(frame_cnt), 64'(v.cnt));
    chk($sformatf("r%0d meas_pix", i), 64'(meas_pix), 64'(v.mpix));
    chk($sformatf("r%0d meas_line", i), 64'(meas_line), 64'(v.mline));
    chk($sformatf("r%0d frame_done0", i), 64'(frame_done0), 64'(v.acc0));
    tick;
    chk($sformatf("r%0d done_pulse", i), 64'(frame_done), 64'(0));
    chk($sformatf("r%0d busy_after", i), 64'(busy), 64'(v.busy));
    repeat (20) tick;
    prev_mode = v.mode;
  endtask

  initial begin
    //          st poke nl np pre           mid           acc a0 err cnt mpix mline mode       busy
    vt[0]  = '{0, 3, 11, 30, MODE_RGB,     MODE_RGB,     0, 0, 0, 0, 0,  0,  MODE_RGB,   0};
    vt[1]  = '{0, 0, 11, 30, MODE_RGB,     MODE_RGB,     0, 1, 0, 0, 0,  0,  MODE_RGB,   0};
    vt[2]  = '{1, 0, 11, 30, MODE_RGB,     MODE_RGB,     0, 1, 0, 0, 0,  0,  MODE_RGB,   1};
    vt[3]  = '{0, 0, 11, 30, MODE_RGB,     MODE_RGB,     0, 1, 0, 0, 0,  0,  MODE_RGB,   1};
    vt[4]  = '{0, 0, 11, 30, MODE_RGB,     MODE_YCBCR,   1, 1, 0, 1, 30, 11, MODE_RGB,   1};
    vt[5]  = '{0, 0, 11, 30, MODE_YCBCR,   MODE_YCBCR,   1, 1, 0, 2, 30, 11, MODE_YCBCR, 1};
    vt[6]  = '{0, 0, 11, 30, MODE_MASK,    MODE_OVERLAY, 1, 1, 0, 3, 30, 11, MODE_MASK,  1};
    vt[7]  = '{0, 0, 10, 30, MODE_OVERLAY, MODE_OVERLAY, 1, 1, 1, 4, 30, 10, MODE_OVERLAY, 1};
    vt[8]  = '{0, 0, 11, 30, MODE_RGB,     MODE_RGB,     1, 1, 0, 5, 30, 11, MODE_RGB,   1};
    vt[9]  = '{0, 0, 11, 29, MODE_YCBCR,   MODE_YCBCR,   1, 1, 1, 6, 29, 11, MODE_YCBCR, 1};
    vt[10] = '{0, 1, 11, 30, MODE_MASK,    MODE_MASK,    1, 1, 0, 7, 30, 11, MODE_MASK,  0};
    vt[11] = '{0, 0, 11, 30, MODE_OVERLAY, MODE_OVERLAY, 0, 1, 0, 7, 30, 11, MODE_MASK,  0};
    vt[12] = '{1, 0, 11, 30, MODE_RGB,     MODE_RGB,     0, 1, 0, 7, 30, 11, MODE_MASK,  1};
    vt[13] = '{0, 0, 11, 30, MODE_RGB,     MODE_RGB,     0, 1, 0, 7, 30, 11, MODE_MASK,  1};
    vt[14] = '{0, 0, 11, 30, MODE_YCBCR,   MODE_YCBCR,   1, 1, 0, 8, 30, 11, MODE_YCBCR, 1};
    vt[15] = '{0, 2, 11, 30, MODE_OVERLAY, MODE_OVERLAY, 0, 1, 0, 8, 30, 11, MODE_YCBCR, 0};
    vrst   = '{0, 0, 11, 30, MODE_MASK,    MODE_MASK,    0, 0, 0, 0, 0,  0,  MODE_RGB,   0};

    rst_n = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0; start0 = 1'b0;
    in_vsync = 1'b0; in_clken = 1'b0; in_valid = 1'b0; mode_req = 2'd0;
    prev_mode = 2'd0;
    repeat (5) tick;
    chk("reset_state", 64'({proc_en, mode_cur, frame_start, frame_done, frame_err,
                            frame_cnt, meas_pix, meas_line, busy}), 64'(0));
    chk("reset_state0", 64'({proc_en0, mode_cur0, frame_start0, frame_done0, frame_err0,
                             frame_cnt0, meas_pix0, meas_line0, busy0}), 64'(0));
    rst_n = 1'b1;
    repeat (300) tick;

    for (int i = 0; i < 16; i++)
      run_row(i, vt[i]);

    // Reset in the middle of an accepted frame of the SKIP_FRAMES=0 instance.
    ctrl_start = 1'b1;
    tick;
    ctrl_start = 1'b0;
    repeat (3) tick;
    in_vsync = 1'b1;
    tick;
    blank(2);
    repeat (3) line(30);
    chk("pre_reset_run0", 64'(proc_en0), 64'(1));
    rst_n = 1'b0;
    tick;
    chk("midrun_reset", 64'({proc_en, mode_cur, frame_start, frame_done, frame_err,
                             frame_cnt, meas_pix, meas_line, busy}), 64'(0));
    chk("midrun_reset0", 64'({proc_en0, mode_cur0, frame_start0, frame_done0, frame_err0,
                              frame_cnt0, meas_pix0, meas_line0, busy0}), 64'(0));
    repeat (4) tick;
    rst_n = 1'b1;
    watch = 1'b1;
    repeat (8) line(30);
    blank(3);
    in_vsync = 1'b0;
    repeat (21) tick;
    prev_mode = 2'd0;
    run_row(16, vrst);
    tick;
    chk("no_activity_after_reset", 64'(act_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
